// File: rtl/eth_fcs_append_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : eth_fcs_append_pkg                                          |
// | Brief   : Shared Ethernet constants, FSM state type and the per-byte  |
// |           reflected CRC-32 step function.                             |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package eth_fcs_append_pkg;

  localparam logic [31:0] c_crc_init    = 32'hFFFF_FFFF;
  localparam logic [31:0] c_crc_residue = 32'hDEBB_20E3;
  localparam logic [31:0] c_crc_poly    = 32'hEDB8_8320;
  localparam logic [7:0]  c_pad_byte    = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAD  = 2'd2,
    ST_FCS  = 2'd3
  } fcs_state_t;

  // Reflected CRC-32, LSB first, one byte folded per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                              input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_fcs_append_crc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : eth_fcs_append_crc                                          |
// | Brief   : Combinational single-byte CRC-32 update.                    |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module eth_fcs_append_crc
  import eth_fcs_append_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  // Fold one byte into the running CRC.
  always_comb begin
    crc_out = crc32_byte(crc_in, data_in);
  end

endmodule
`default_nettype wire

// File: rtl/eth_fcs_append.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : eth_fcs_append                                              |
// | Brief   : Streams an Ethernet payload through, optionally zero-pads   |
// |           it to MIN_PAYLOAD_BYTES, and appends the 4-byte FCS.        |
// |           Define ETH_FCS_PAD_EN to compile in the padding stage.      |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module eth_fcs_append
  import eth_fcs_append_pkg::*;
#(
  parameter int MIN_PAYLOAD_BYTES = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_done
);

  localparam logic [5:0] c_min = 6'(MIN_PAYLOAD_BYTES);
`ifdef ETH_FCS_PAD_EN
  localparam bit c_pad_en = 1'b1;
`else
  localparam bit c_pad_en = 1'b0;
`endif

  fcs_state_t  r_state;
  fcs_state_t  w_state_nxt;
  logic [31:0] r_crc;
  logic [31:0] w_crc_nxt;
  logic [5:0]  r_count;
  logic [5:0]  w_count_nxt;
  logic [1:0]  r_fcs_idx;
  logic [1:0]  w_fcs_idx_nxt;
  logic [7:0]  r_out_data;
  logic [7:0]  w_out_data_nxt;
  logic        r_out_valid;
  logic        w_out_valid_nxt;
  logic        r_out_last;
  logic        w_out_last_nxt;

  logic        w_adv;
  logic        w_accept;
  logic        w_in_ready;
  logic [5:0]  w_count_inc;
  logic        w_pad_needed;
  logic [7:0]  w_crc_byte;
  logic [31:0] w_crc_step;

  // The output register may be reloaded when empty or being drained.
  assign w_adv        = !r_out_valid || out_ready;
  assign w_in_ready   = ((r_state == ST_IDLE) || (r_state == ST_DATA)) && w_adv;
  assign w_accept     = in_valid && w_in_ready;
  // Count saturates so long frames never look short again.
  assign w_count_inc  = (r_count == 6'd63) ? 6'd63 : (r_count + 6'd1);
  assign w_pad_needed = c_pad_en && (w_count_inc < c_min);
  assign w_crc_byte   = (r_state == ST_PAD) ? c_pad_byte : in_data;

  eth_fcs_append_crc u_crc (
    .crc_in  (r_crc),
    .data_in (w_crc_byte),
    .crc_out (w_crc_step)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DATA: begin
        if (w_accept) begin
          if (in_last) begin
            w_state_nxt = w_pad_needed ? ST_PAD : ST_FCS;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
      end
`ifdef ETH_FCS_PAD_EN
      ST_PAD: begin
        if (w_adv && (w_count_inc == c_min)) begin
          w_state_nxt = ST_FCS;
        end
      end
`endif
      ST_FCS: begin
        // Leave only once the final FCS byte has actually been taken.
        if (w_adv && r_out_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath next values: output byte, CRC, length count, FCS index.
  always_comb begin
    w_crc_nxt       = r_crc;
    w_count_nxt     = r_count;
    w_fcs_idx_nxt   = r_fcs_idx;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    case (r_state)
      ST_IDLE, ST_DATA: begin
        if (w_accept) begin
          w_crc_nxt       = w_crc_step;
          w_count_nxt     = w_count_inc;
          w_out_data_nxt  = in_data;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = 1'b0;
        end else if (w_adv) begin
          w_out_valid_nxt = 1'b0;
        end
      end
`ifdef ETH_FCS_PAD_EN
      ST_PAD: begin
        if (w_adv) begin
          w_crc_nxt       = w_crc_step;
          w_count_nxt     = w_count_inc;
          w_out_data_nxt  = c_pad_byte;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = 1'b0;
        end
      end
`endif
      ST_FCS: begin
        if (w_adv) begin
          if (r_out_last) begin
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
            w_crc_nxt       = c_crc_init;
            w_count_nxt     = 6'd0;
            w_fcs_idx_nxt   = 2'd0;
          end else begin
            w_out_data_nxt  = ~r_crc[{r_fcs_idx, 3'b000} +: 8];
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = (r_fcs_idx == 2'd3);
            w_fcs_idx_nxt   = r_fcs_idx + 2'd1;
          end
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc       <= c_crc_init;
      r_count     <= 6'd0;
      r_fcs_idx   <= 2'd0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_crc       <= w_crc_nxt;
      r_count     <= w_count_nxt;
      r_fcs_idx   <= w_fcs_idx_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign frame_done = r_out_valid && r_out_last && out_ready;

endmodule
`default_nettype wire
